// File: rtl/display_timing_pkg.sv
// Shared display timing presets and coordinate width used by raster
// timing generators in the pixel clock domain.
package display_timing_pkg;

    localparam int CORDW_DEFAULT = 16;

    // 640x480 at 60 Hz, both syncs active-low
    localparam int VGA_H_RES  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_RES  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam bit VGA_H_POL  = 1'b0;
    localparam bit VGA_V_POL  = 1'b0;

    // 1280x720 at 60 Hz, both syncs active-high
    localparam int HD_H_RES  = 1280;
    localparam int HD_H_FP   = 110;
    localparam int HD_H_SYNC = 40;
    localparam int HD_H_BP   = 220;
    localparam int HD_V_RES  = 720;
    localparam int HD_V_FP   = 5;
    localparam int HD_V_SYNC = 5;
    localparam int HD_V_BP   = 20;
    localparam bit HD_H_POL  = 1'b1;
    localparam bit HD_V_POL  = 1'b1;

    function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/display_timing.sv
// Raster timing generator: pixel/line counters plus registered decode of
// de, syncs and line/frame strobes, all aligned to the same (sx, sy).
module display_timing
    import display_timing_pkg::*;
#(
    parameter int H_RES  = VGA_H_RES,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_RES  = VGA_V_RES,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter bit H_POL  = VGA_H_POL,
    parameter bit V_POL  = VGA_V_POL,
    parameter int CORDW  = CORDW_DEFAULT
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line,
    output logic             frame
);

    localparam int     H_TOTAL   = axis_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL   = axis_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam longint CORD_SPAN = longint'(1) << CORDW;

    if (longint'(H_TOTAL) > CORD_SPAN) begin : g_h_total_too_big
        $error("display_timing: H_TOTAL does not fit in CORDW bits");
    end
    if (longint'(V_TOTAL) > CORD_SPAN) begin : g_v_total_too_big
        $error("display_timing: V_TOTAL does not fit in CORDW bits");
    end

    // Decode bounds carry one extra bit so an edge equal to 2^CORDW stays representable.
    localparam int XW = CORDW + 1;
    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW:0]   H_DE_END = XW'(H_RES);
    localparam logic [CORDW:0]   HS_BEG   = XW'(H_RES + H_FP);
    localparam logic [CORDW:0]   HS_END   = XW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW:0]   V_DE_END = XW'(V_RES);
    localparam logic [CORDW:0]   VS_BEG   = XW'(V_RES + V_FP);
    localparam logic [CORDW:0]   VS_END   = XW'(V_RES + V_FP + V_SYNC);

    logic [CORDW-1:0] sx_p0, sy_p0;
    logic [CORDW:0]   sx_w, sy_w;
    logic             de_p0, hsync_p0, vsync_p0, line_p0, frame_p0;

    // p0: next position and its decode, so registered outputs never skew
    always_comb begin
        sx_p0 = sx + CORDW'(1);
        sy_p0 = sy;
        if (sx == H_LAST) begin
            sx_p0 = '0;
            sy_p0 = (sy == V_LAST) ? '0 : sy + CORDW'(1);
        end
        sx_w     = {1'b0, sx_p0};
        sy_w     = {1'b0, sy_p0};
        de_p0    = (sx_w < H_DE_END) && (sy_w < V_DE_END);
        hsync_p0 = ((sx_w >= HS_BEG) && (sx_w < HS_END)) ? H_POL : ~H_POL;
        vsync_p0 = ((sy_w >= VS_BEG) && (sy_w < VS_END)) ? V_POL : ~V_POL;
        line_p0  = (sx_p0 == '0);
        frame_p0 = line_p0 && (sy_p0 == '0);
    end

    // p1: output registers; reset parks on the last pixel so release starts a frame
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            sx    <= H_LAST;
            sy    <= V_LAST;
            de    <= 1'b0;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            line  <= 1'b0;
            frame <= 1'b0;
        end else begin
            sx    <= sx_p0;
            sy    <= sy_p0;
            de    <= de_p0;
            hsync <= hsync_p0;
            vsync <= vsync_p0;
            line  <= line_p0;
            frame <= frame_p0;
        end
    end

endmodule

// File: tb/tb_display_timing.sv
// Directed bench for display_timing: default 640x480, 720p preset, and two
// small timings (16x8 total) that make vertical and frame behaviour reachable quickly.
module tb_display_timing;
    import display_timing_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    logic [15:0] a_sx, a_sy, b_sx, b_sy;
    logic [3:0]  c_sx, c_sy;
    logic [7:0]  d_sx, d_sy;
    logic a_de, a_hs, a_vs, a_ln, a_fr;
    logic b_de, b_hs, b_vs, b_ln, b_fr;
    logic c_de, c_hs, c_vs, c_ln, c_fr;
    logic d_de, d_hs, d_vs, d_ln, d_fr;

    display_timing u_vga (
        .clk_pix(clk), .rst_pix(rst), .sx(a_sx), .sy(a_sy), .de(a_de),
        .hsync(a_hs), .vsync(a_vs), .line(a_ln), .frame(a_fr)
    );

    display_timing #(
        .H_RES(HD_H_RES), .H_FP(HD_H_FP), .H_SYNC(HD_H_SYNC), .H_BP(HD_H_BP),
        .V_RES(HD_V_RES), .V_FP(HD_V_FP), .V_SYNC(HD_V_SYNC), .V_BP(HD_V_BP),
        .H_POL(HD_H_POL), .V_POL(HD_V_POL), .CORDW(16)
    ) u_hd (
        .clk_pix(clk), .rst_pix(rst), .sx(b_sx), .sy(b_sy), .de(b_de),
        .hsync(b_hs), .vsync(b_vs), .line(b_ln), .frame(b_fr)
    );

    // H_TOTAL = 16 = 2^CORDW exactly: the largest timing the width allows
    display_timing #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CORDW(4)
    ) u_sml (
        .clk_pix(clk), .rst_pix(rst), .sx(c_sx), .sy(c_sy), .de(c_de),
        .hsync(c_hs), .vsync(c_vs), .line(c_ln), .frame(c_fr)
    );

    display_timing #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CORDW(8)
    ) u_smh (
        .clk_pix(clk), .rst_pix(rst), .sx(d_sx), .sy(d_sy), .de(d_de),
        .hsync(d_hs), .vsync(d_vs), .line(d_ln), .frame(d_fr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves every instance on its first pixel (0,0)
    task automatic restart();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        ncmp++; if (a_sx !== 16'd799) begin nerr++; $display("FAIL rst_sx: got %0d want 799", a_sx); end
        ncmp++; if (a_sy !== 16'd524) begin nerr++; $display("FAIL rst_sy: got %0d want 524", a_sy); end
        ncmp++; if (a_de !== 1'b0) begin nerr++; $display("FAIL rst_de: got %b want 0", a_de); end
        ncmp++; if (a_hs !== 1'b1) begin nerr++; $display("FAIL rst_hsync: got %b want 1", a_hs); end
        ncmp++; if (a_vs !== 1'b1) begin nerr++; $display("FAIL rst_vsync: got %b want 1", a_vs); end
        ncmp++; if (a_ln !== 1'b0) begin nerr++; $display("FAIL rst_line: got %b want 0", a_ln); end
        ncmp++; if (a_fr !== 1'b0) begin nerr++; $display("FAIL rst_frame: got %b want 0", a_fr); end
        ncmp++; if (b_sx !== 16'd1649 || b_sy !== 16'd749) begin nerr++; $display("FAIL rst_hd_pos: got %0d,%0d want 1649,749", b_sx, b_sy); end
        ncmp++; if (b_hs !== 1'b0 || b_vs !== 1'b0) begin nerr++; $display("FAIL rst_hd_sync: got %b%b want 00", b_hs, b_vs); end
        ncmp++; if (c_sx !== 4'd15 || c_sy !== 4'd7) begin nerr++; $display("FAIL rst_sml_pos: got %0d,%0d want 15,7", c_sx, c_sy); end
        rst = 1'b0;
        tick();
        ncmp++; if (a_sx !== 16'd0 || a_sy !== 16'd0) begin nerr++; $display("FAIL rel_pos: got %0d,%0d want 0,0", a_sx, a_sy); end
        ncmp++; if (a_de !== 1'b1) begin nerr++; $display("FAIL rel_de: got %b want 1", a_de); end
        ncmp++; if (a_ln !== 1'b1) begin nerr++; $display("FAIL rel_line: got %b want 1", a_ln); end
        ncmp++; if (a_fr !== 1'b1) begin nerr++; $display("FAIL rel_frame: got %b want 1", a_fr); end
        ncmp++; if (a_hs !== 1'b1 || a_vs !== 1'b1) begin nerr++; $display("FAIL rel_sync: got %b%b want 11", a_hs, a_vs); end
        ncmp++; if (c_sx !== 4'd0 || c_sy !== 4'd0 || c_fr !== 1'b1) begin nerr++; $display("FAIL rel_sml: got %0d,%0d fr=%b want 0,0 fr=1", c_sx, c_sy, c_fr); end
    endtask

    // One full line at sy=10 on the default timing
    task automatic test_hline();
        restart();
        for (int i = 0; i < 8000; i++) tick();
        ncmp++; if (a_sx !== 16'd0 || a_sy !== 16'd10) begin nerr++; $display("FAIL hl_start: got %0d,%0d want 0,10", a_sx, a_sy); end
        for (int i = 0; i < 800; i++) begin
            ncmp++; if (a_sx !== 16'(i) || a_sy !== 16'd10) begin nerr++; $display("FAIL hl_pos: got %0d,%0d want %0d,10", a_sx, a_sy, i); end
            ncmp++; if (a_de !== (i < 640)) begin nerr++; $display("FAIL hl_de sx=%0d: got %b want %b", i, a_de, (i < 640)); end
            ncmp++; if (a_hs !== !(i >= 656 && i < 752)) begin nerr++; $display("FAIL hl_hsync sx=%0d: got %b want %b", i, a_hs, !(i >= 656 && i < 752)); end
            ncmp++; if (a_ln !== (i == 0)) begin nerr++; $display("FAIL hl_line sx=%0d: got %b want %b", i, a_ln, (i == 0)); end
            ncmp++; if (a_vs !== 1'b1 || a_fr !== 1'b0) begin nerr++; $display("FAIL hl_vs_fr sx=%0d: got %b%b want 10", i, a_vs, a_fr); end
            tick();
        end
        ncmp++; if (a_sx !== 16'd0 || a_sy !== 16'd11 || a_ln !== 1'b1) begin nerr++; $display("FAIL hl_wrap: got %0d,%0d ln=%b want 0,11 ln=1", a_sx, a_sy, a_ln); end
    endtask

    // Whole small frame: every pixel against a hand model, both polarities
    task automatic test_vertical();
        int x, y;
        restart();
        for (int i = 0; i < 128; i++) begin
            x = i % 16;
            y = i / 16;
            ncmp++; if (c_sx !== 4'(x) || c_sy !== 4'(y)) begin nerr++; $display("FAIL vt_pos: got %0d,%0d want %0d,%0d", c_sx, c_sy, x, y); end
            ncmp++; if (c_de !== (x < 8 && y < 4)) begin nerr++; $display("FAIL vt_de %0d,%0d: got %b want %b", x, y, c_de, (x < 8 && y < 4)); end
            ncmp++; if (c_vs !== !(y >= 5 && y < 7)) begin nerr++; $display("FAIL vt_vsync_lo %0d,%0d: got %b want %b", x, y, c_vs, !(y >= 5 && y < 7)); end
            ncmp++; if (c_hs !== !(x >= 10 && x < 13)) begin nerr++; $display("FAIL vt_hsync_lo %0d,%0d: got %b want %b", x, y, c_hs, !(x >= 10 && x < 13)); end
            ncmp++; if (c_ln !== (x == 0) || c_fr !== (i == 0)) begin nerr++; $display("FAIL vt_strobe %0d,%0d: got ln=%b fr=%b want ln=%b fr=%b", x, y, c_ln, c_fr, (x == 0), (i == 0)); end
            ncmp++; if (d_vs !== (y >= 5 && y < 7) || d_hs !== (x >= 10 && x < 13)) begin nerr++; $display("FAIL vt_sync_hi %0d,%0d: got hs=%b vs=%b", x, y, d_hs, d_vs); end
            tick();
        end
        ncmp++; if (c_sx !== 4'd0 || c_sy !== 4'd0 || c_fr !== 1'b1 || c_ln !== 1'b1) begin nerr++; $display("FAIL vt_frame_wrap: got %0d,%0d ln=%b fr=%b want 0,0 ln=1 fr=1", c_sx, c_sy, c_ln, c_fr); end
    endtask

    // Strobe spacing measured with bounded waits
    task automatic test_periods();
        int n;
        restart();
        n = 0;
        do begin tick(); n++; end while (c_fr !== 1'b1 && n < 400);
        ncmp++; if (n !== 128) begin nerr++; $display("FAIL frame_period: got %0d want 128", n); end
        n = 0;
        do begin tick(); n++; end while (c_ln !== 1'b1 && n < 100);
        ncmp++; if (n !== 16) begin nerr++; $display("FAIL line_period_sml: got %0d want 16", n); end
        restart();
        n = 0;
        do begin tick(); n++; end while (a_ln !== 1'b1 && n < 2000);
        ncmp++; if (n !== 800) begin nerr++; $display("FAIL line_period_vga: got %0d want 800", n); end
    endtask

    task automatic test_midframe_reset();
        restart();
        for (int i = 0; i < 300; i++) tick();
        ncmp++; if (a_sx !== 16'd300 || c_sx !== 4'd12 || c_sy !== 4'd2) begin nerr++; $display("FAIL mr_pre: got vga sx=%0d sml %0d,%0d want 300 12,2", a_sx, c_sx, c_sy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++; if (a_sx !== 16'd799 || a_sy !== 16'd524) begin nerr++; $display("FAIL mr_pos: got %0d,%0d want 799,524", a_sx, a_sy); end
        ncmp++; if (a_de !== 1'b0 || a_ln !== 1'b0 || a_fr !== 1'b0) begin nerr++; $display("FAIL mr_ctl: got de=%b ln=%b fr=%b want 000", a_de, a_ln, a_fr); end
        ncmp++; if (c_sx !== 4'd15 || c_sy !== 4'd7 || c_hs !== 1'b1) begin nerr++; $display("FAIL mr_sml: got %0d,%0d hs=%b want 15,7 hs=1", c_sx, c_sy, c_hs); end
        tick();
        ncmp++; if (a_sx !== 16'd0 || a_sy !== 16'd0 || a_fr !== 1'b1 || a_de !== 1'b1) begin nerr++; $display("FAIL mr_resume: got %0d,%0d fr=%b de=%b want 0,0 fr=1 de=1", a_sx, a_sy, a_fr, a_de); end
        ncmp++; if (c_sx !== 4'd0 || c_sy !== 4'd0 || c_fr !== 1'b1) begin nerr++; $display("FAIL mr_resume_sml: got %0d,%0d fr=%b want 0,0 fr=1", c_sx, c_sy, c_fr); end
    endtask

    // First line of the 720p preset with active-high syncs
    task automatic test_preset_720p();
        restart();
        for (int i = 0; i < 1650; i++) begin
            ncmp++; if (b_sx !== 16'(i) || b_sy !== 16'd0) begin nerr++; $display("FAIL hd_pos: got %0d,%0d want %0d,0", b_sx, b_sy, i); end
            ncmp++; if (b_hs !== (i >= 1390 && i < 1430)) begin nerr++; $display("FAIL hd_hsync sx=%0d: got %b want %b", i, b_hs, (i >= 1390 && i < 1430)); end
            ncmp++; if (b_de !== (i < 1280) || b_vs !== 1'b0) begin nerr++; $display("FAIL hd_de_vs sx=%0d: got de=%b vs=%b", i, b_de, b_vs); end
            tick();
        end
        ncmp++; if (b_sx !== 16'd0 || b_sy !== 16'd1 || b_ln !== 1'b1 || b_fr !== 1'b0) begin nerr++; $display("FAIL hd_wrap: got %0d,%0d ln=%b fr=%b want 0,1 ln=1 fr=0", b_sx, b_sy, b_ln, b_fr); end
    endtask

    initial begin
        test_reset();
        test_hline();
        test_vertical();
        test_periods();
        test_midframe_reset();
        test_preset_720p();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
